// File: rtl/apb_i2c_cmd_arbiter.sv
// Two-requester round-robin arbiter that issues one APB transfer per grant.
// Ports: PCLK/PRESET, REQ_* requester side, RSP_*/BUSY status, P* APB master.
module apb_i2c_cmd_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [1:0]  REQ_VALID,
  input  logic [1:0]  REQ_WRITE,
  input  logic [3:0]  REQ_REG,
  input  logic [63:0] REQ_WDATA,
  output logic [1:0]  REQ_ACK,
  output logic [31:0] RSP_RDATA,
  output logic        RSP_ERR,
  output logic        BUSY,
  output logic        PSELx,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam logic [7:0] TO = 8'(TIMEOUT_CYCLES);

  logic [1:0]  state_q, state_d;
  logic        last_q, last_d;
  logic        gnt_q, gnt_d;
  logic        wr_q, wr_d;
  logic [1:0]  reg_q, reg_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        gnt;
  logic        sel_wr;
  logic [1:0]  sel_reg;
  logic [31:0] sel_wdata;
  logic        illegal;
  logic [7:0]  cnt_inc;
  logic        st_idle, st_setup;
  logic        st_access, st_resp;
  logic        apb_on;

  assign st_idle   = (state_q == S_IDLE);
  assign st_setup  = (state_q == S_SETUP);
  assign st_access = (state_q == S_ACCESS);
  assign st_resp   = (state_q == S_RESP);

  // Tie goes to whoever was not granted last.
  always_comb begin
    if (REQ_VALID == 2'b11) gnt = ~last_q;
    else                    gnt = REQ_VALID[1];
  end

  assign sel_wr    = REQ_WRITE[gnt];
  assign sel_reg   = gnt ? REQ_REG[3:2] : REQ_REG[1:0];
  assign sel_wdata = gnt ? REQ_WDATA[63:32]
                         : REQ_WDATA[31:0];

  // RX FIFO is read-only, TX FIFO is write-only.
  assign illegal = ( sel_wr && sel_reg == 2'd1) ||
                   (!sel_wr && sel_reg == 2'd0);

  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    wr_d    = wr_q;
    reg_d   = reg_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (1'b1)
      st_idle: begin
        if (|REQ_VALID) begin
          gnt_d   = gnt;
          last_d  = gnt;
          wr_d    = sel_wr;
          reg_d   = sel_reg;
          wdata_d = sel_wdata;
          if (illegal) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            cnt_d   = 8'd0;
            state_d = S_SETUP;
          end
        end
      end
      st_setup: begin
        state_d = S_ACCESS;
      end
      st_access: begin
        // PREADY takes priority over an expiring count.
        if (PREADY) begin
          err_d = PSLVERR;
          if (!wr_q) rdata_d = PRDATA;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TO) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      st_resp: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      wr_q    <= 1'b0;
      reg_q   <= 2'd0;
      wdata_q <= 32'd0;
      cnt_q   <= 8'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      wr_q    <= wr_d;
      reg_q   <= reg_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign apb_on    = st_setup | st_access;
  assign PSELx     = apb_on;
  assign PENABLE   = st_access;
  assign PWRITE    = apb_on & wr_q;
  assign PADDR     = apb_on ? {28'd0, reg_q, 2'b00}
                            : 32'd0;
  assign PWDATA    = apb_on ? wdata_q : 32'd0;
  assign BUSY      = ~st_idle;
  assign REQ_ACK   = st_resp ? (gnt_q ? 2'b10 : 2'b01)
                             : 2'b00;
  assign RSP_RDATA = rdata_q;
  assign RSP_ERR   = err_q;

endmodule

// File: tb/tb_apb_i2c_cmd_arbiter.sv
// Directed bench for apb_i2c_cmd_arbiter: vector table plus
// hand-written arbitration, timeout-boundary and reset sequences.
module tb_apb_i2c_cmd_arbiter;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic [1:0]  REQ_VALID;
  logic [1:0]  REQ_WRITE;
  logic [3:0]  REQ_REG;
  logic [63:0] REQ_WDATA;
  logic [1:0]  REQ_ACK;
  logic [31:0] RSP_RDATA;
  logic        RSP_ERR;
  logic        BUSY;
  logic        PSELx;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  always #5 PCLK = ~PCLK;

  apb_i2c_cmd_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .REQ_VALID(REQ_VALID), .REQ_WRITE(REQ_WRITE),
    .REQ_REG(REQ_REG), .REQ_WDATA(REQ_WDATA),
    .REQ_ACK(REQ_ACK), .RSP_RDATA(RSP_RDATA),
    .RSP_ERR(RSP_ERR), .BUSY(BUSY),
    .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  typedef struct {
    logic        r;
    logic        w;
    logic [1:0]  rg;
    logic [31:0] wd;
    logic [31:0] prd;
    logic        slv;
    int          dly;
    logic        e_err;
    logic [31:0] e_rd;
    int          e_edges;
    logic        e_apb;
  } vec_t;

  vec_t tbl[9];
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h",
               nm, act, exp);
    end
  endtask

  task automatic drive_one(input logic r, input logic w,
                           input logic [1:0] rg,
                           input logic [31:0] wd);
    REQ_VALID = r ? 2'b10 : 2'b01;
    REQ_WRITE = r ? {w, 1'b0} : {1'b0, w};
    REQ_REG   = r ? {rg, 2'b00} : {2'b00, rg};
    REQ_WDATA = r ? {wd, 32'd0} : {32'd0, wd};
  endtask

  // Steps the clock until ACK, acting as an APB slave that
  // raises PREADY after dly wait cycles (dly<0: never).
  task automatic wait_ack(input int dly,
                          input logic [31:0] prd,
                          input logic slv,
                          input logic [31:0] eaddr,
                          input logic ew,
                          input logic [31:0] ewd,
                          output int edges, output int acc,
                          output logic [1:0] ack,
                          output logic sawp, output logic bad,
                          output logic pack);
    edges = 0; acc = 0; ack = 2'b00;
    sawp = 1'b0; bad = 1'b0; pack = 1'b0;
    PRDATA = prd; PSLVERR = slv; PREADY = 1'b0;
    for (int c = 0; c < 64; c++) begin
      @(posedge PCLK);
      edges++;
      @(negedge PCLK);
      if (REQ_ACK != 2'b00) begin
        ack = REQ_ACK;
        pack = PSELx | PENABLE;
        PREADY = 1'b0;
        return;
      end
      if (PSELx) begin
        sawp = 1'b1;
        if (PADDR !== eaddr || PWRITE !== ew ||
            PWDATA !== (ew ? ewd : PWDATA))
          bad = 1'b1;
      end
      if (PSELx && PENABLE) begin
        acc++;
        PREADY = (dly >= 0 && acc > dly);
      end else begin
        PREADY = 1'b0;
      end
    end
    chk("ack_timeout", 32'(edges), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge PCLK);
    PRESET = 1'b1;
    REQ_VALID = '0; REQ_WRITE = '0;
    REQ_REG = '0; REQ_WDATA = '0;
    PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    repeat (2) @(negedge PCLK);
    PRESET = 1'b0;
  endtask

  int edges, acc;
  logic [1:0] ack;
  logic sawp, bad, pack;

  initial begin
    tbl[0] = '{1'b0, 1'b1, 2'd2, 32'h0000_1A2B, 32'h0,
               1'b0, 0, 1'b0, 32'h0, 3, 1'b1};
    tbl[1] = '{1'b1, 1'b0, 2'd1, 32'h0, 32'h55,
               1'b0, 2, 1'b0, 32'h55, 5, 1'b1};
    tbl[2] = '{1'b1, 1'b0, 2'd1, 32'h0, 32'hDEAD,
               1'b0, -1, 1'b1, 32'h55, 18, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 2'd1, 32'h99, 32'h0,
               1'b0, 0, 1'b1, 32'h55, 1, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 2'd0, 32'h0, 32'h0,
               1'b0, 0, 1'b1, 32'h55, 1, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 2'd3, 32'h77, 32'hBEEF,
               1'b1, 0, 1'b1, 32'h55, 3, 1'b1};
    tbl[6] = '{1'b1, 1'b0, 2'd2, 32'h0, 32'hCAFE_F00D,
               1'b0, 1, 1'b0, 32'hCAFE_F00D, 4, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 2'd3, 32'h0, 32'h1234,
               1'b0, 15, 1'b0, 32'h1234, 18, 1'b1};
    tbl[8] = '{1'b1, 1'b1, 2'd0, 32'hABCD, 32'h0,
               1'b0, 0, 1'b0, 32'h1234, 3, 1'b1};

    PRESET = 1'b1;
    REQ_VALID = '0; REQ_WRITE = '0;
    REQ_REG = '0; REQ_WDATA = '0;
    PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    repeat (2) @(negedge PCLK);
    chk("rst_ack", 32'(REQ_ACK), 32'd0);
    chk("rst_rdata", RSP_RDATA, 32'd0);
    chk("rst_err", 32'(RSP_ERR), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_psel_pen_pwr",
        32'({PSELx, PENABLE, PWRITE}), 32'd0);
    chk("rst_paddr", PADDR, 32'd0);
    chk("rst_pwdata", PWDATA, 32'd0);
    PRESET = 1'b0;

    for (int i = 0; i < 9; i++) begin
      @(negedge PCLK);
      drive_one(tbl[i].r, tbl[i].w, tbl[i].rg, tbl[i].wd);
      wait_ack(tbl[i].dly, tbl[i].prd, tbl[i].slv,
               {28'd0, tbl[i].rg, 2'b00}, tbl[i].w,
               tbl[i].wd, edges, acc, ack, sawp, bad, pack);
      REQ_VALID = '0;
      chk($sformatf("v%0d_ack", i), 32'(ack),
          tbl[i].r ? 32'd2 : 32'd1);
      chk($sformatf("v%0d_err", i), 32'(RSP_ERR),
          32'(tbl[i].e_err));
      chk($sformatf("v%0d_rdata", i), RSP_RDATA, tbl[i].e_rd);
      chk($sformatf("v%0d_edges", i), 32'(edges),
          32'(tbl[i].e_edges));
      chk($sformatf("v%0d_apb", i), 32'(sawp),
          32'(tbl[i].e_apb));
      chk($sformatf("v%0d_bus", i), 32'(bad), 32'd0);
      chk($sformatf("v%0d_psel_resp", i), 32'(pack), 32'd0);
      @(posedge PCLK);
      @(negedge PCLK);
      chk($sformatf("v%0d_idle", i), 32'(BUSY), 32'd0);
    end

    // Timeout vector must spend exactly 16 cycles in ACCESS.
    @(negedge PCLK);
    drive_one(1'b1, 1'b0, 2'd1, 32'h0);
    wait_ack(-1, 32'h0, 1'b0, 32'h4, 1'b0, 32'h0,
             edges, acc, ack, sawp, bad, pack);
    REQ_VALID = '0;
    chk("to_access_cycles", 32'(acc), 32'd16);
    chk("to_err", 32'(RSP_ERR), 32'd1);
    chk("to_ack", 32'(ack), 32'd2);
    @(posedge PCLK);

    // Tie after reset: req0 first, one IDLE gap, then req1.
    do_reset();
    REQ_VALID = 2'b11; REQ_WRITE = 2'b00;
    REQ_REG = 4'b0101; REQ_WDATA = '0;
    wait_ack(0, 32'h11, 1'b0, 32'h4, 1'b0, 32'h0,
             edges, acc, ack, sawp, bad, pack);
    REQ_VALID = 2'b10;
    chk("rr_ack0", 32'(ack), 32'd1);
    chk("rr_rdata0", RSP_RDATA, 32'h11);
    chk("rr_edges0", 32'(edges), 32'd3);
    wait_ack(0, 32'h22, 1'b0, 32'h4, 1'b0, 32'h0,
             edges, acc, ack, sawp, bad, pack);
    REQ_VALID = 2'b00;
    chk("rr_ack1", 32'(ack), 32'd2);
    chk("rr_rdata1", RSP_RDATA, 32'h22);
    chk("rr_edges1", 32'(edges), 32'd4);
    @(posedge PCLK);

    // VALID dropped after grant still completes.
    @(negedge PCLK);
    drive_one(1'b1, 1'b1, 2'd2, 32'h5A5A);
    @(posedge PCLK);
    @(negedge PCLK);
    REQ_VALID = 2'b00;
    chk("drop_busy", 32'(BUSY), 32'd1);
    wait_ack(0, 32'h0, 1'b0, 32'h8, 1'b1, 32'h5A5A,
             edges, acc, ack, sawp, bad, pack);
    chk("drop_ack", 32'(ack), 32'd2);
    chk("drop_edges", 32'(edges), 32'd2);
    chk("drop_bus", 32'(bad), 32'd0);
    @(posedge PCLK);

    // Asynchronous reset in ACCESS, then tie resolves to req0.
    @(negedge PCLK);
    drive_one(1'b1, 1'b0, 2'd2, 32'h0);
    PREADY = 1'b0;
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    chk("ar_in_access", 32'({PSELx, PENABLE}), 32'd3);
    #2 PRESET = 1'b1;
    #1;
    chk("ar_psel_pen", 32'({PSELx, PENABLE}), 32'd0);
    chk("ar_busy", 32'(BUSY), 32'd0);
    chk("ar_ack", 32'(REQ_ACK), 32'd0);
    @(negedge PCLK);
    PRESET = 1'b0;
    REQ_VALID = 2'b11; REQ_WRITE = 2'b00;
    REQ_REG = 4'b1010;
    wait_ack(0, 32'h3C, 1'b0, 32'h8, 1'b0, 32'h0,
             edges, acc, ack, sawp, bad, pack);
    REQ_VALID = 2'b00;
    chk("ar_next_ack", 32'(ack), 32'd1);
    chk("ar_next_rdata", RSP_RDATA, 32'h3C);
    chk("ar_next_err", 32'(RSP_ERR), 32'd0);
    chk("ar_next_edges", 32'(edges), 32'd3);
    @(posedge PCLK);
    @(negedge PCLK);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
